// File: rtl/rcvr_ctrl.sv
// rcvr_ctrl: captures bytes from the serial frame receiver into a small
// circular FIFO, strobes rx_reading to release each byte, counts receiver
// overrun events and offers buffered bytes to one consumer via valid/pop.
module rcvr_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic          rx_ready,
    input  logic          rx_overrun,
    input  logic [7:0]    rx_data,
    output logic          rx_reading,
    output logic          out_valid,
    output logic [7:0]    out_data,
    input  logic          out_pop,
    output logic [AW:0]   fifo_level,
    output logic [7:0]    ovr_count,
    input  logic          clr_ovr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic            ovr_prev_q, ovr_prev_d;
    logic [7:0]      ovr_count_q, ovr_count_d;
    logic [7:0]      mem_q [DEPTH];

    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            ovr_rise;

    assign fifo_full  = (level_q == LVL_FULL);
    assign fifo_empty = (level_q == '0);
    assign pop        = out_pop && !fifo_empty;
    assign ovr_rise   = rx_overrun && !ovr_prev_q;

    // Next-state logic: capture only from IDLE, one READ strobe per byte,
    // park in FULL while the buffer has no room so the receiver keeps its byte.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_ready && en) begin
                    if (fifo_full) begin
                        state_d = FULL;
                    end else begin
                        push    = 1'b1;
                        state_d = READ;
                    end
                end
            end
            READ: state_d = IDLE;
            FULL: begin
                if (!fifo_full || !en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointer and level bookkeeping; push and pop may coincide.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LVL_ONE;
        end
    end

    // Overrun edge detection with a saturating counter; clear wins.
    always_comb begin
        ovr_prev_d  = rx_overrun;
        ovr_count_d = ovr_count_q;
        if (clr_ovr) begin
            ovr_count_d = '0;
        end else if (ovr_rise && (ovr_count_q != 8'hFF)) begin
            ovr_count_d = ovr_count_q + 8'd1;
        end
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ovr_prev_q  <= 1'b0;
            ovr_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovr_prev_q  <= ovr_prev_d;
            ovr_count_q <= ovr_count_d;
        end
    end

    // Byte storage; contents are meaningless until the pointers cover them.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    assign rx_reading = (state_q == READ);
    assign out_valid  = !fifo_empty;
    assign out_data   = mem_q[rd_ptr_q];
    assign fifo_level = level_q;
    assign ovr_count  = ovr_count_q;

endmodule

// File: tb/tb_rcvr_ctrl.sv
// Bench for rcvr_ctrl: directed stimulus, a queue-based reference model
// checked every cycle, plus literal expectations at key points.
module tb_rcvr_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          rx_ready = 1'b0;
    logic          rx_overrun = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_reading;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_pop = 1'b0;
    logic [AW:0]   fifo_level;
    logic [7:0]    ovr_count;
    logic          clr_ovr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    rcvr_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .rx_ready   (rx_ready),
        .rx_overrun (rx_overrun),
        .rx_data    (rx_data),
        .rx_reading (rx_reading),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_pop    (out_pop),
        .fifo_level (fifo_level),
        .ovr_count  (ovr_count),
        .clr_ovr    (clr_ovr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes in a queue, rules taken from the behaviour text.
    logic [7:0] mq [$];
    int         m_cnt;
    bit         m_prev_ovr;
    bit         m_strobe;     // a byte was taken at the previous edge
    bit         m_stalled;    // waiting for room with a byte pending
    bit         m_full, m_cap, m_stall_new;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_cnt      = 0;
            m_prev_ovr = 0;
            m_strobe   = 0;
            m_stalled  = 0;
        end else begin
            m_full      = (mq.size() == DEPTH);
            m_cap       = !m_strobe && !m_stalled && rx_ready && en && !m_full;
            m_stall_new = m_stalled ? (m_full && en)
                                    : (!m_strobe && rx_ready && en && m_full);
            if (out_pop && mq.size() > 0) void'(mq.pop_front());
            if (m_cap) mq.push_back(rx_data);
            if (clr_ovr) m_cnt = 0;
            else if (rx_overrun && !m_prev_ovr && m_cnt < 255) m_cnt = m_cnt + 1;
            m_prev_ovr = rx_overrun;
            m_strobe   = m_cap;
            m_stalled  = m_stall_new;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (chk_en && !reset) begin
            chk("m_reading", rx_reading, m_strobe);
            chk("m_valid", out_valid, mq.size() != 0);
            chk("m_level", fifo_level, mq.size());
            chk("m_ovr", ovr_count, m_cnt);
            if (mq.size() != 0) chk("m_data", out_data, mq[0]);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One-cycle ready pulse followed by the READ cycle.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(1);
    endtask

    task automatic drain(input logic [7:0] b);
        chk("drain_data", out_data, b);
        out_pop = 1'b1;
        tick(1);
        out_pop = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_reading", rx_reading, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovr", ovr_count, 0);
        tick(2);
        reset  = 1'b0;
        en     = 1'b1;
        chk_en = 1'b1;
        tick(1);

        // Single frame
        rx_data  = 8'h3C;
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        chk("sf_reading", rx_reading, 1);
        chk("sf_valid", out_valid, 1);
        chk("sf_data", out_data, 8'h3C);
        chk("sf_level", fifo_level, 1);
        tick(1);
        chk("sf_reading_off", rx_reading, 0);
        out_pop = 1'b1;
        tick(1);
        out_pop = 1'b0;
        chk("sf_level_pop", fifo_level, 0);

        // Fill and stall
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        chk("fill_level", fifo_level, 4);
        rx_data  = 8'h05;
        rx_ready = 1'b1;
        tick(3);
        chk("stall_reading", rx_reading, 0);
        chk("stall_level", fifo_level, 4);
        out_pop = 1'b1;
        tick(1);
        out_pop = 1'b0;
        chk("stall_pop_level", fifo_level, 3);
        chk("stall_pop_reading", rx_reading, 0);
        tick(1);
        chk("stall_wait_reading", rx_reading, 0);
        tick(1);
        rx_ready = 1'b0;
        chk("stall_cap_reading", rx_reading, 1);
        chk("stall_cap_level", fifo_level, 4);
        tick(1);
        drain(8'h02); drain(8'h03); drain(8'h04); drain(8'h05);
        chk("stall_empty", out_valid, 0);

        // Simultaneous push/pop
        send(8'h11); send(8'h22);
        rx_data  = 8'hAA;
        rx_ready = 1'b1;
        out_pop  = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        out_pop  = 1'b0;
        chk("pp_level", fifo_level, 2);
        chk("pp_reading", rx_reading, 1);
        tick(1);
        drain(8'h22); drain(8'hAA);

        // Enable gating
        en       = 1'b0;
        rx_data  = 8'h5A;
        rx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("en_reading", rx_reading, 0);
        end
        chk("en_level", fifo_level, 0);
        en = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        chk("en_cap_reading", rx_reading, 1);
        chk("en_cap_level", fifo_level, 1);
        tick(1);
        drain(8'h5A);

        // Overrun counting
        for (int k = 0; k < 2; k++) begin
            rx_overrun = 1'b1;
            tick(3);
            rx_overrun = 1'b0;
            tick(2);
        end
        chk("ovr_two", ovr_count, 2);
        rx_overrun = 1'b1;
        clr_ovr    = 1'b1;
        tick(1);
        rx_overrun = 1'b0;
        clr_ovr    = 1'b0;
        chk("ovr_clr_edge", ovr_count, 0);
        tick(1);
        for (int k = 0; k < 300; k++) begin
            rx_overrun = 1'b1;
            tick(1);
            rx_overrun = 1'b0;
            tick(1);
        end
        chk("ovr_sat", ovr_count, 255);
        clr_ovr = 1'b1;
        tick(1);
        clr_ovr = 1'b0;
        chk("ovr_clr", ovr_count, 0);

        // Async reset during READ with level 3
        rx_overrun = 1'b1;
        tick(1);
        rx_overrun = 1'b0;
        chk("ar_ovr_pre", ovr_count, 1);
        send(8'h61); send(8'h62);
        rx_data  = 8'h63;
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        chk("ar_pre_reading", rx_reading, 1);
        chk("ar_pre_level", fifo_level, 3);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_reading", rx_reading, 0);
        chk("ar_valid", out_valid, 0);
        chk("ar_level", fifo_level, 0);
        chk("ar_ovr", ovr_count, 0);
        tick(2);
        reset = 1'b0;
        tick(1);
        send(8'h7E);
        drain(8'h7E);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
